// File: rtl/stopwatch_pkg.sv
// Shared definitions for the countdown timer datapath and its controller.
package stopwatch_pkg;

    localparam int TIME_W = 6;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] RUN   = 2'd1;
    localparam logic [1:0] PAUSE = 2'd2;
    localparam logic [1:0] ALARM = 2'd3;

    localparam logic [TIME_W-1:0] MAX_SEC = 6'd59;
    localparam logic [TIME_W-1:0] MAX_MIN = 6'd59;

    // Increment a time field, wrapping from max_value back to zero.
    function automatic logic [TIME_W-1:0] wrap_inc(input logic [TIME_W-1:0] value,
                                                   input logic [TIME_W-1:0] max_value);
        logic [TIME_W-1:0] result;
        if (value >= max_value) begin
            result = 6'd0;
        end else begin
            result = value + 6'd1;
        end
        return result;
    endfunction

endpackage

// File: rtl/stopwatch_controller_btn_edge_detect.sv
// Turns a synchronised button level into a one-cycle press pulse.
// A button already held when reset is released never produces a press.
module btn_edge_detect (
    input  logic clk,
    input  logic rst,
    input  logic level,
    output logic press
);

    logic level_prev_r;
    logic armed_r;

    // Track the previous level and arm the detector one cycle after reset
    always_ff @(posedge clk) begin
        if (rst) begin
            level_prev_r <= 1'b0;
            armed_r      <= 1'b0;
        end else begin
            level_prev_r <= level;
            armed_r      <= 1'b1;
        end
    end

    assign press = level & ~level_prev_r & armed_r;

endmodule

// File: rtl/stopwatch_controller.sv
// Countdown timer control FSM: button handling, preset editing, load/run
// sequencing, one-per-second tick generation and a timed alarm.
module stopwatch_controller
    import stopwatch_pkg::*;
#(
    parameter int TICK_DIV   = 50_000_000,
    parameter int ALARM_SECS = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              btn_start,
    input  logic              btn_clear,
    input  logic              btn_inc_min,
    input  logic              btn_inc_sec,
    input  logic              timer_finish,
    output logic [TIME_W-1:0] preset_minutes,
    output logic [TIME_W-1:0] preset_seconds,
    output logic              load,
    output logic              run_en,
    output logic              tick,
    output logic              alarm,
    output logic [1:0]        state_o
);

    localparam int DIV_W = $clog2(TICK_DIV);
    localparam int CNT_W = $clog2(ALARM_SECS + 1);
    localparam logic [DIV_W-1:0] DIV_MAX  = DIV_W'(TICK_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ALARM_SECS - 1);

    logic              start_press_s, clear_press_s, inc_min_press_s, inc_sec_press_s;
    logic [1:0]        state_r, state_nx_s;
    logic [TIME_W-1:0] min_r, min_nx_s, sec_r, sec_nx_s;
    logic              load_r, load_nx_s, run_en_r, alarm_r, tick_s;
    logic [DIV_W-1:0]  div_r, div_nx_s, div_step_s;
    logic [CNT_W-1:0]  cnt_r, cnt_nx_s;
    logic              div_at_max_s, preset_nonzero_s;

    btn_edge_detect u_start   (.clk(clk), .rst(rst), .level(btn_start),   .press(start_press_s));
    btn_edge_detect u_clear   (.clk(clk), .rst(rst), .level(btn_clear),   .press(clear_press_s));
    btn_edge_detect u_inc_min (.clk(clk), .rst(rst), .level(btn_inc_min), .press(inc_min_press_s));
    btn_edge_detect u_inc_sec (.clk(clk), .rst(rst), .level(btn_inc_sec), .press(inc_sec_press_s));

    assign div_at_max_s     = (div_r == DIV_MAX);
    assign div_step_s       = div_at_max_s ? {DIV_W{1'b0}} : div_r + DIV_W'(1);
    assign preset_nonzero_s = (min_r != 6'd0) || (sec_r != 6'd0);

    // Next-state, preset, divider and alarm-counter decisions for this cycle.
    // The divider only advances while the FSM stays in RUN (or ALARM), so a
    // pause freezes it exactly where it was and leaving RUN never emits a tick.
    always_comb begin
        state_nx_s = state_r;
        min_nx_s   = min_r;
        sec_nx_s   = sec_r;
        load_nx_s  = 1'b0;
        div_nx_s   = div_r;
        cnt_nx_s   = cnt_r;
        tick_s     = 1'b0;
        case (state_r)
            IDLE: begin
                div_nx_s = {DIV_W{1'b0}};
                if (clear_press_s) begin
                    load_nx_s = 1'b1;
                end else if (start_press_s) begin
                    if (preset_nonzero_s) begin
                        state_nx_s = RUN;
                        load_nx_s  = 1'b1;
                    end else begin
                        state_nx_s = IDLE;
                    end
                end else begin
                    if (inc_min_press_s) begin
                        min_nx_s = wrap_inc(min_r, MAX_MIN);
                    end else begin
                        min_nx_s = min_r;
                    end
                    if (inc_sec_press_s) begin
                        sec_nx_s = wrap_inc(sec_r, MAX_SEC);
                    end else begin
                        sec_nx_s = sec_r;
                    end
                end
            end
            RUN: begin
                if (clear_press_s) begin
                    state_nx_s = IDLE;
                    load_nx_s  = 1'b1;
                    div_nx_s   = {DIV_W{1'b0}};
                end else if (start_press_s) begin
                    state_nx_s = PAUSE;
                end else if (timer_finish && !load_r) begin
                    // load_r marks the first RUN cycle, where finish is stale
                    state_nx_s = ALARM;
                    div_nx_s   = {DIV_W{1'b0}};
                    cnt_nx_s   = {CNT_W{1'b0}};
                end else begin
                    div_nx_s = div_step_s;
                    tick_s   = div_at_max_s;
                end
            end
            PAUSE: begin
                if (clear_press_s) begin
                    state_nx_s = IDLE;
                    load_nx_s  = 1'b1;
                    div_nx_s   = {DIV_W{1'b0}};
                end else if (start_press_s) begin
                    state_nx_s = RUN;
                end else begin
                    state_nx_s = PAUSE;
                end
            end
            ALARM: begin
                if (clear_press_s) begin
                    state_nx_s = IDLE;
                    load_nx_s  = 1'b1;
                    div_nx_s   = {DIV_W{1'b0}};
                end else if (start_press_s) begin
                    state_nx_s = IDLE;
                    div_nx_s   = {DIV_W{1'b0}};
                end else begin
                    div_nx_s = div_step_s;
                    if (div_at_max_s) begin
                        if (cnt_r == CNT_LAST) begin
                            state_nx_s = IDLE;
                            cnt_nx_s   = {CNT_W{1'b0}};
                        end else begin
                            cnt_nx_s = cnt_r + CNT_W'(1);
                        end
                    end else begin
                        cnt_nx_s = cnt_r;
                    end
                end
            end
            default: begin
                state_nx_s = IDLE;
                div_nx_s   = {DIV_W{1'b0}};
            end
        endcase
    end

    // Register state, presets, divider, alarm counter and the control outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= IDLE;
            min_r    <= 6'd0;
            sec_r    <= 6'd0;
            load_r   <= 1'b0;
            run_en_r <= 1'b0;
            alarm_r  <= 1'b0;
            div_r    <= {DIV_W{1'b0}};
            cnt_r    <= {CNT_W{1'b0}};
        end else begin
            state_r  <= state_nx_s;
            min_r    <= min_nx_s;
            sec_r    <= sec_nx_s;
            load_r   <= load_nx_s;
            run_en_r <= (state_nx_s == RUN);
            alarm_r  <= (state_nx_s == ALARM);
            div_r    <= div_nx_s;
            cnt_r    <= cnt_nx_s;
        end
    end

    assign preset_minutes = min_r;
    assign preset_seconds = sec_r;
    assign load           = load_r;
    assign run_en         = run_en_r;
    assign alarm          = alarm_r;
    assign state_o        = state_r;
    assign tick           = tick_s & ~rst;

endmodule

// File: tb/tb_stopwatch_controller.sv
// Self-checking bench for stopwatch_controller with TICK_DIV=4, ALARM_SECS=3.
// Each vector holds the inputs for one cycle, the tick expected during that
// cycle and the registered outputs expected after the closing clock edge.
module tb_stopwatch_controller;

    typedef struct {
        int         id;
        logic       rst, start, clear, imin, isec, fin;
        logic       tick;
        logic [1:0] state;
        logic       load, run, alarm;
        logic [5:0] min, sec;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0, btn_start = 1'b0, btn_clear = 1'b0;
    logic       btn_inc_min = 1'b0, btn_inc_sec = 1'b0, timer_finish = 1'b0;
    logic [5:0] preset_minutes, preset_seconds;
    logic       load, run_en, tick, alarm;
    logic [1:0] state_o;

    int   errors = 0;
    int   checks = 0;
    int   nvec   = 0;
    logic done   = 1'b0;
    logic tick_obs;
    vec_t sb[$];
    vec_t tbl[$];

    stopwatch_controller #(.TICK_DIV(4), .ALARM_SECS(3)) dut (
        .clk(clk), .rst(rst), .btn_start(btn_start), .btn_clear(btn_clear),
        .btn_inc_min(btn_inc_min), .btn_inc_sec(btn_inc_sec), .timer_finish(timer_finish),
        .preset_minutes(preset_minutes), .preset_seconds(preset_seconds),
        .load(load), .run_en(run_en), .tick(tick), .alarm(alarm), .state_o(state_o)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic r, s, c, m, q, f, input logic t,
                                input logic [1:0] st, input logic ld, rn, al,
                                input logic [5:0] mn, sc);
        vec_t v;
        v.id = 0; v.rst = r; v.start = s; v.clear = c; v.imin = m; v.isec = q; v.fin = f;
        v.tick = t; v.state = st; v.load = ld; v.run = rn; v.alarm = al; v.min = mn; v.sec = sc;
        return v;
    endfunction

    task automatic apply(input vec_t v);
        @(negedge clk);
        rst = v.rst; btn_start = v.start; btn_clear = v.clear;
        btn_inc_min = v.imin; btn_inc_sec = v.isec; timer_finish = v.fin;
        v.id = nvec;
        nvec = nvec + 1;
        sb.push_back(v);
    endtask

    task automatic chk(input string name, input int id, input logic [7:0] act, input logic [7:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s @vec %0d: got %0d expected %0d", name, id, act, exp);
        end
    endtask

    // tick is combinational: capture it mid-cycle, well clear of the edges
    always @(negedge clk) begin
        #2;
        tick_obs = tick;
    end

    // Scoreboard: pop the expectation for the cycle that just closed
    always @(posedge clk) begin
        vec_t e;
        #1;
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("tick",  e.id, 8'(tick_obs),       8'(e.tick));
            chk("state", e.id, 8'(state_o),        8'(e.state));
            chk("load",  e.id, 8'(load),           8'(e.load));
            chk("run_en",e.id, 8'(run_en),         8'(e.run));
            chk("alarm", e.id, 8'(alarm),          8'(e.alarm));
            chk("min",   e.id, 8'(preset_minutes), 8'(e.min));
            chk("sec",   e.id, 8'(preset_seconds), 8'(e.sec));
        end else if (done) begin
            $display("Result: errors=%0d of %0d checks", errors, checks);
            $finish;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Test 1: reset, preset editing, held button counts once
        tbl.push_back(mk(1,0,0,0,0,0, 0,2'd0,0,0,0, 6'd0,6'd0));
        tbl.push_back(mk(0,0,0,0,0,0, 0,2'd0,0,0,0, 6'd0,6'd0));
        tbl.push_back(mk(0,0,0,1,0,0, 0,2'd0,0,0,0, 6'd1,6'd0));
        tbl.push_back(mk(0,0,0,0,0,0, 0,2'd0,0,0,0, 6'd1,6'd0));
        tbl.push_back(mk(0,0,0,1,0,0, 0,2'd0,0,0,0, 6'd2,6'd0));
        tbl.push_back(mk(0,0,0,0,0,0, 0,2'd0,0,0,0, 6'd2,6'd0));
        tbl.push_back(mk(0,0,0,0,1,0, 0,2'd0,0,0,0, 6'd2,6'd1));
        tbl.push_back(mk(0,0,0,0,0,0, 0,2'd0,0,0,0, 6'd2,6'd1));
        tbl.push_back(mk(0,0,0,0,1,0, 0,2'd0,0,0,0, 6'd2,6'd2));
        tbl.push_back(mk(0,0,0,0,0,0, 0,2'd0,0,0,0, 6'd2,6'd2));
        tbl.push_back(mk(0,0,0,0,1,0, 0,2'd0,0,0,0, 6'd2,6'd3));
        tbl.push_back(mk(0,0,0,0,0,0, 0,2'd0,0,0,0, 6'd2,6'd3));
        for (int i = 0; i < 10; i++) tbl.push_back(mk(0,0,0,0,1,0, 0,2'd0,0,0,0, 6'd2,6'd4));
        tbl.push_back(mk(0,0,0,0,0,0, 0,2'd0,0,0,0, 6'd2,6'd4));
        tbl.push_back(mk(0,0,0,1,1,0, 0,2'd0,0,0,0, 6'd3,6'd5));
        tbl.push_back(mk(0,0,0,0,0,0, 0,2'd0,0,0,0, 6'd3,6'd5));
        for (int i = 0; i < tbl.size(); i++) apply(tbl[i]);

        // Test 2: 60 second presses from zero wrap back to zero
        apply(mk(1,0,0,0,0,0, 0,2'd0,0,0,0, 6'd0,6'd0));
        apply(mk(0,0,0,0,0,0, 0,2'd0,0,0,0, 6'd0,6'd0));
        for (int k = 1; k <= 60; k++) begin
            apply(mk(0,0,0,0,1,0, 0,2'd0,0,0,0, 6'd0,6'(k % 60)));
            apply(mk(0,0,0,0,0,0, 0,2'd0,0,0,0, 6'd0,6'(k % 60)));
        end

        // Test 3: preset 00:02, run with ticks, finish -> timed alarm
        apply(mk(0,0,0,0,1,0, 0,2'd0,0,0,0, 6'd0,6'd1));
        apply(mk(0,0,0,0,0,0, 0,2'd0,0,0,0, 6'd0,6'd1));
        apply(mk(0,0,0,0,1,0, 0,2'd0,0,0,0, 6'd0,6'd2));
        apply(mk(0,0,0,0,0,0, 0,2'd0,0,0,0, 6'd0,6'd2));
        apply(mk(0,1,0,0,0,0, 0,2'd1,1,1,0, 6'd0,6'd2));
        for (int k = 1; k <= 12; k++)
            apply(mk(0,0,0,0,0,0, (k % 4 == 0),2'd1,0,1,0, 6'd0,6'd2));
        apply(mk(0,0,0,0,0,1, 0,2'd3,0,0,1, 6'd0,6'd2));
        for (int j = 1; j <= 12; j++)
            apply(mk(0,0,0,0,0,0, 0,(j < 12) ? 2'd3 : 2'd0,0,0,(j < 12), 6'd0,6'd2));

        // Test 4: pause at divider 2, resume, then clear+start together
        apply(mk(0,1,0,0,0,0, 0,2'd1,1,1,0, 6'd0,6'd2));
        apply(mk(0,0,0,0,0,0, 0,2'd1,0,1,0, 6'd0,6'd2));
        apply(mk(0,0,0,0,0,0, 0,2'd1,0,1,0, 6'd0,6'd2));
        apply(mk(0,1,0,0,0,0, 0,2'd2,0,0,0, 6'd0,6'd2));
        for (int i = 0; i < 20; i++)
            apply(mk(0,0,0,0,0,(i >= 5 && i < 9), 0,2'd2,0,0,0, 6'd0,6'd2));
        apply(mk(0,1,0,0,0,0, 0,2'd1,0,1,0, 6'd0,6'd2));
        apply(mk(0,0,0,0,0,0, 0,2'd1,0,1,0, 6'd0,6'd2));
        apply(mk(0,0,0,0,0,0, 1,2'd1,0,1,0, 6'd0,6'd2));
        apply(mk(0,1,1,0,0,0, 0,2'd0,1,0,0, 6'd0,6'd2));
        apply(mk(0,0,0,0,0,0, 0,2'd0,0,0,0, 6'd0,6'd2));

        // Test 5b: finish high through the load cycle is ignored; start ends ALARM
        apply(mk(0,1,0,0,0,1, 0,2'd1,1,1,0, 6'd0,6'd2));
        apply(mk(0,0,0,0,0,1, 0,2'd1,0,1,0, 6'd0,6'd2));
        apply(mk(0,0,0,0,0,0, 0,2'd1,0,1,0, 6'd0,6'd2));
        apply(mk(0,0,0,0,0,1, 0,2'd3,0,0,1, 6'd0,6'd2));
        apply(mk(0,1,0,0,0,0, 0,2'd0,0,0,0, 6'd0,6'd2));
        apply(mk(0,0,0,0,0,0, 0,2'd0,0,0,0, 6'd0,6'd2));

        // Test 6: reset mid-RUN overrides a same-cycle press
        apply(mk(0,1,0,0,0,0, 0,2'd1,1,1,0, 6'd0,6'd2));
        apply(mk(0,0,0,0,0,0, 0,2'd1,0,1,0, 6'd0,6'd2));
        apply(mk(0,0,0,0,0,0, 0,2'd1,0,1,0, 6'd0,6'd2));
        apply(mk(1,1,0,0,1,0, 0,2'd0,0,0,0, 6'd0,6'd0));
        apply(mk(0,1,0,0,0,0, 0,2'd0,0,0,0, 6'd0,6'd0));
        apply(mk(0,0,0,0,0,0, 0,2'd0,0,0,0, 6'd0,6'd0));

        // Test 5a: start with 00:00 is ignored; clear in IDLE reloads the preset
        apply(mk(0,1,0,0,0,0, 0,2'd0,0,0,0, 6'd0,6'd0));
        apply(mk(0,0,0,0,0,0, 0,2'd0,0,0,0, 6'd0,6'd0));
        apply(mk(0,0,0,0,1,0, 0,2'd0,0,0,0, 6'd0,6'd1));
        apply(mk(0,0,0,0,0,0, 0,2'd0,0,0,0, 6'd0,6'd1));
        apply(mk(0,0,1,0,0,0, 0,2'd0,1,0,0, 6'd0,6'd1));
        apply(mk(0,0,0,0,0,0, 0,2'd0,0,0,0, 6'd0,6'd1));

        done = 1'b1;
    end

endmodule
